uart_rx_core: RTL and testbench

- UART receiver: 8N1 serial frames on rx become parallel bytes on po_data with a one-cycle po_flag strobe.
- Pairs with the existing 8N1 transmitter: same BPS/clock parameters, same byte/flag style.
- Sits between the board RX pin and the command/data path feeding the SD logic.
- Adds input synchronisation, 3-sample majority voting, start-glitch rejection and framing-error reporting.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_sync.sv | 28 ++
 rtl/uart_rx_core.sv | 126 ++++++++++++
 tb/tb_uart_rx_core.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared 8N1 UART constants, state encoding and baud-divider helpers.
// The transmitter can use the same definitions.
package uart_pkg;

   localparam int DATA_BITS = 8;
   localparam int STOP_IDX  = 9;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } rx_state_e;

   function automatic int baud_cnt_max(input int clk_freq, input int uart_bps);
      return clk_freq / uart_bps;
   endfunction

   // Centre of a bit period, in baud_cnt ticks
   function automatic int mid_point(input int cnt_max);
      return cnt_max / 2;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Three-flop synchroniser for the asynchronous rx pin plus falling-edge detect.
// Flops reset to 1 so an idle-high line produces no edge after reset.
module uart_rx_sync (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic rx,
   output logic s2,
   output logic fall_edge
);

   logic s1;
   logic s3;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
         s3 <= 1'b1;
      end else begin
         s1 <= rx;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign fall_edge = !s2 && s3;

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: synchronised rx, 3-sample majority per bit, start-glitch
// rejection and framing-error reporting; bytes appear on po_data with po_flag.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int UART_BPS = 9600,
   parameter int CLK_FREQ = 50_000_000
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       rx,
   output logic [7:0] po_data,
   output logic       po_flag,
   output logic       po_frame_err,
   output logic       rx_busy
);

   localparam int BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
   localparam int MID          = mid_point(BAUD_CNT_MAX);
   localparam int CW           = $clog2(BAUD_CNT_MAX);

   localparam logic [CW-1:0] CNT_LAST   = CW'(BAUD_CNT_MAX - 1);
   localparam logic [CW-1:0] CNT_MID_M1 = CW'(MID - 1);
   localparam logic [CW-1:0] CNT_MID    = CW'(MID);
   localparam logic [CW-1:0] CNT_MID_P1 = CW'(MID + 1);

   if (BAUD_CNT_MAX < 8) begin : g_bad_baud
      $error("uart_rx_core: CLK_FREQ/UART_BPS must be at least 8");
   end

   logic            s2;
   logic            fall_edge;
   rx_state_e       state;
   rx_state_e       next_state;
   logic [CW-1:0]   baud_cnt;
   logic [3:0]      bit_idx;
   logic [1:0]      samp;
   logic            bit_val;
   logic            at_decide;
   logic            at_wrap;
   logic [7:0]      shift_reg;
   logic            shift_en;
   logic            flag_set;
   logic            err_set;

   uart_rx_sync u_sync (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .rx        (rx),
      .s2        (s2),
      .fall_edge (fall_edge)
   );

   assign at_decide = (baud_cnt == CNT_MID_P1);
   assign at_wrap   = (baud_cnt == CNT_LAST);

   // Third vote is the live s2 on the decision edge
   assign bit_val = (samp[0] & samp[1]) | (samp[0] & s2) | (samp[1] & s2);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state <= IDLE;
      else            state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:      if (fall_edge) next_state = START;
         START: begin
            if (at_decide && bit_val) next_state = IDLE;
            else if (at_wrap)         next_state = DATA;
         end
         DATA:      if (at_wrap && bit_idx == 4'(DATA_BITS)) next_state = STOP;
         STOP:      if (at_decide) next_state = bit_val ? IDLE : WAIT_IDLE;
         WAIT_IDLE: if (s2) next_state = IDLE;
         default:   next_state = IDLE;
      endcase
   end

   always_comb begin
      rx_busy  = (state != IDLE);
      shift_en = (state == DATA) && at_decide;
      flag_set = (state == STOP) && at_decide && bit_val;
      err_set  = (state == STOP) && at_decide && !bit_val;
   end

   // Counter held at zero in IDLE so it starts from 0 on the edge leaving IDLE
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         baud_cnt <= '0;
         bit_idx  <= '0;
      end else if (state == IDLE) begin
         baud_cnt <= '0;
         bit_idx  <= '0;
      end else if (at_wrap) begin
         baud_cnt <= '0;
         bit_idx  <= bit_idx + 4'd1;
      end else begin
         baud_cnt <= baud_cnt + 1'b1;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         samp <= 2'b11;
      end else begin
         if (baud_cnt == CNT_MID_M1) samp[0] <= s2;
         if (baud_cnt == CNT_MID)    samp[1] <= s2;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         shift_reg    <= '0;
         po_data      <= '0;
         po_flag      <= 1'b0;
         po_frame_err <= 1'b0;
      end else begin
         if (shift_en) shift_reg <= {bit_val, shift_reg[7:1]};
         if (flag_set) po_data <= shift_reg;
         po_flag      <= flag_set;
         po_frame_err <= err_set;
      end
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed scoreboard bench for uart_rx_core at 10 clocks per bit.
module tb_uart_rx_core;

   localparam int B = 10;

   logic       sys_clk;
   logic       sys_rst_n;
   logic       rx;
   logic [7:0] po_data;
   logic       po_flag;
   logic       po_frame_err;
   logic       rx_busy;

   typedef struct packed {
      logic        err;
      logic [7:0]  data;
      logic [31:0] cyc;
   } ev_t;

   ev_t         exp_q[$];
   ev_t         obs_q[$];
   int unsigned cyc;
   int          both_cnt;
   int          checks;
   int          errors;
   logic [7:0]  last_good;

   uart_rx_core #(.UART_BPS(100_000), .CLK_FREQ(1_000_000)) dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .rx           (rx),
      .po_data      (po_data),
      .po_flag      (po_flag),
      .po_frame_err (po_frame_err),
      .rx_busy      (rx_busy)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   initial cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   initial both_cnt = 0;
   always @(negedge sys_clk) begin
      if (sys_rst_n) begin
         if (po_flag)      obs_q.push_back('{err: 1'b0, data: po_data, cyc: cyc});
         if (po_frame_err) obs_q.push_back('{err: 1'b1, data: po_data, cyc: cyc});
         if (po_flag && po_frame_err) both_cnt <= both_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic sync_clk();
      @(posedge sys_clk);
      #1;
   endtask

   // Caller is #1 after an edge; the next edge captures the start bit (t0)
   task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                             input bit glitch, output int unsigned t0);
      logic b;
      t0 = cyc + 1;
      for (int k = 0; k < 10; k++) begin
         b = (k == 0) ? 1'b0 : (k <= 8) ? d[k-1] : stop_bit;
         rx = b;
         if (glitch && k >= 1 && k <= 8) begin
            tick(6);
            rx = ~b;
            tick(1);
            rx = b;
            tick(3);
         end else begin
            tick(B);
         end
      end
   endtask

   task automatic expect_flag(input logic [7:0] d, input int unsigned t0);
      exp_q.push_back('{err: 1'b0, data: d, cyc: t0 + 99});
      last_good = d;
   endtask

   task automatic drain(input string tag);
      ev_t e;
      ev_t o;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() == 0) begin
            chk({tag, "_missing_event"}, 32'd0, 32'd1);
         end else begin
            o = obs_q.pop_front();
            chk({tag, "_kind"}, 32'(o.err), 32'(e.err));
            chk({tag, "_data"}, 32'(o.data), 32'(e.data));
            chk({tag, "_cycle"}, o.cyc, e.cyc);
         end
      end
      chk({tag, "_extra_events"}, obs_q.size(), 0);
      obs_q.delete();
   endtask

   initial begin
      int unsigned t0;
      int unsigned ta;
      int unsigned tb;
      int unsigned tc;
      int unsigned r;
      checks    = 0;
      errors    = 0;
      last_good = 8'h00;
      rx        = 1'b1;
      sys_rst_n = 1'b0;

      // Reset state
      tick(3);
      chk("rst_po_data", 32'(po_data), 0);
      chk("rst_po_flag", 32'(po_flag), 0);
      chk("rst_po_frame_err", 32'(po_frame_err), 0);
      chk("rst_rx_busy", 32'(rx_busy), 0);
      sys_rst_n = 1'b1;
      tick(5);

      // Single ideal frame
      send_frame(8'hA5, 1'b1, 1'b0, t0);
      expect_flag(8'hA5, t0);
      tick(5);
      drain("a5");
      chk("a5_po_data", 32'(po_data), 32'hA5);

      // Back-to-back frames, no idle gap
      sync_clk();
      send_frame(8'h00, 1'b1, 1'b0, ta);
      send_frame(8'hFF, 1'b1, 1'b0, tb);
      send_frame(8'h3C, 1'b1, 1'b0, tc);
      expect_flag(8'h00, ta);
      expect_flag(8'hFF, tb);
      expect_flag(8'h3C, tc);
      tick(5);
      drain("b2b");
      chk("b2b_spacing", tc - ta, 200);

      // Two-cycle start glitch
      sync_clk();
      rx = 1'b0;
      t0 = cyc + 1;
      tick(2);
      rx = 1'b1;
      tick(1);
      chk("glitch_busy_rise", 32'(rx_busy), 1);
      tick(10);
      chk("glitch_busy_fall", 32'(rx_busy), 0);
      chk("glitch_po_data", 32'(po_data), 32'(last_good));
      tick(20);
      drain("glitch");

      // Framing error followed by a held-low break
      sync_clk();
      send_frame(8'h55, 1'b0, 1'b0, t0);
      exp_q.push_back('{err: 1'b1, data: last_good, cyc: t0 + 99});
      tick(290);
      chk("brk_busy_held", 32'(rx_busy), 1);
      rx = 1'b1;
      r = cyc + 1;
      tick(2);
      chk("brk_busy_before_idle", 32'(rx_busy), 1);
      chk("brk_release_cyc", cyc, r + 1);
      tick(1);
      chk("brk_busy_after_idle", 32'(rx_busy), 0);
      chk("brk_po_data", 32'(po_data), 32'(last_good));
      drain("brk");
      tick(3);
      send_frame(8'h12, 1'b1, 1'b0, t0);
      expect_flag(8'h12, t0);
      tick(5);
      drain("after_brk");

      // Single-cycle glitch inside every data bit
      sync_clk();
      send_frame(8'h96, 1'b1, 1'b1, t0);
      expect_flag(8'h96, t0);
      tick(5);
      drain("maj");
      chk("maj_po_data", 32'(po_data), 32'h96);

      // Reset during data bit 4
      sync_clk();
      rx = 1'b0;
      tick(B);
      for (int k = 0; k < 4; k++) begin
         rx = (8'h6B >> k) & 8'h01;
         tick(B);
      end
      rx = 1'b1;
      tick(5);
      sys_rst_n = 1'b0;
      #1;
      chk("midrst_po_data", 32'(po_data), 0);
      chk("midrst_po_flag", 32'(po_flag), 0);
      chk("midrst_po_frame_err", 32'(po_frame_err), 0);
      chk("midrst_rx_busy", 32'(rx_busy), 0);
      tick(3);
      sys_rst_n = 1'b1;
      tick(150);
      drain("midrst_quiet");
      send_frame(8'h81, 1'b1, 1'b0, t0);
      expect_flag(8'h81, t0);
      tick(5);
      drain("after_rst");
      chk("after_rst_po_data", 32'(po_data), 32'h81);

      chk("flag_and_err_together", both_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
